// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a DEPTH x 8 FIFO; frames are sent back to back
// while data is queued, with an 8x oversample tick setting the bit time.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BAUD_COUNT = CLK_FREQ / (BAUD * 8);
  localparam int unsigned CNT_W      = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
  localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W      = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]        tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic tick_c;
  logic bit_end_c;
  logic pop_c;
  logic push_ok_c;

  // Oversample tick: counter parked at zero while idle, free-running otherwise
  always_comb begin
    tick_c     = (state_q != S_IDLE) && (baud_cnt_q == CNT_W'(BAUD_COUNT - 1));
    bit_end_c  = tick_c && (tick_cnt_q == 3'd7);
    baud_cnt_d = baud_cnt_q;
    tick_cnt_d = tick_cnt_q;
    if (state_q == S_IDLE) begin
      baud_cnt_d = '0;
      tick_cnt_d = '0;
    end else if (tick_c) begin
      baud_cnt_d = '0;
      tick_cnt_d = tick_cnt_q + 3'd1;
    end else begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and frame datapath; pops only ever happen with empty low
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (!empty_q) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so tx changes on the transition edge
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && bit_end_c;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping; a push when full is accepted only alongside a pop
  always_comb begin
    push_ok_c = push && (!full_q || pop_c);
    wr_ptr_d  = push_ok_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_c ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    level_d   = level_q + LVL_W'(push_ok_c) - LVL_W'(pop_c);
    full_d    = (level_d == LVL_W'(DEPTH));
    empty_d   = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_FREQ=800, BAUD=10 (10 clk/tick,
// 80 clk/bit, 800 clk/frame); frames are checked cycle by cycle on negedges.
module tb_uart_tx_fifo;

  localparam int unsigned BIT_CLK   = 80;
  localparam int unsigned FRAME_CLK = 800;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       tx;
  logic       full;
  logic       empty;
  logic       tx_busy;
  logic       tx_done;

  int n_vec;
  int n_miss;

  uart_tx_fifo #(
    .CLK_FREQ(800),
    .BAUD    (10),
    .DEPTH   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .tx       (tx),
    .full     (full),
    .empty    (empty),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at the negedge that is first_c cycles after tx fell; returns at offset 800
  task automatic frame_check(input logic [7:0] b, input int first_c);
    int         bad;
    int         early_done;
    int         busy_low;
    int         idx;
    logic       lvl;
    logic [7:0] got;
    bad        = 0;
    early_done = 0;
    busy_low   = 0;
    got        = 8'h00;
    for (int c = first_c; c < int'(FRAME_CLK); c++) begin
      idx = c / int'(BIT_CLK);
      if (idx == 0)      lvl = 1'b0;
      else if (idx == 9) lvl = 1'b1;
      else               lvl = b[idx-1];
      if (tx !== lvl) bad++;
      if ((idx >= 1) && (idx <= 8) && ((c % int'(BIT_CLK)) == 40)) got[idx-1] = tx;
      if ((c >= 1) && (tx_done !== 1'b0)) early_done++;
      if (tx_busy !== 1'b1) busy_low++;
      @(negedge clk);
    end
    chk($sformatf("frame_%02h_tx_cycles", b), 32'(bad), 32'd0);
    chk($sformatf("frame_%02h_byte", b), 32'(got), 32'(b));
    chk($sformatf("frame_%02h_busy", b), 32'(busy_low), 32'd0);
    chk($sformatf("frame_%02h_early_done", b), 32'(early_done), 32'd0);
    chk($sformatf("frame_%02h_done", b), 32'(tx_done), 32'd1);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_tx"},    32'(tx),      32'd1);
    chk({tag, "_busy"},  32'(tx_busy), 32'd0);
    chk({tag, "_done"},  32'(tx_done), 32'd0);
    chk({tag, "_empty"}, 32'(empty),   32'd1);
    chk({tag, "_full"},  32'(full),    32'd0);
  endtask

  initial begin
    logic [7:0] exp_q [18];
    logic [7:0] late_b;
    int         bad_tx;
    int         bad_done;
    int         bad_busy;

    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b0;
    push      = 1'b0;
    push_data = 8'h00;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 idle_check("reset_async");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle_check("reset_release");

    // Single byte 0x55: one-edge latency then a full frame
    push      = 1'b1;
    push_data = 8'h55;
    @(negedge clk);
    push = 1'b0;
    chk("lat_tx_still_high", 32'(tx), 32'd1);
    chk("lat_empty_low", 32'(empty), 32'd0);
    @(negedge clk);
    frame_check(8'h55, 0);
    @(negedge clk);
    idle_check("after_55");

    // Three consecutive pushes: contiguous frames in order
    push      = 1'b1;
    push_data = 8'h41;
    @(negedge clk);
    push_data = 8'h0D;
    @(negedge clk);
    push_data = 8'h0A;
    chk("start_lat_41", 32'(tx), 32'd0);
    @(negedge clk);
    push = 1'b0;
    frame_check(8'h41, 1);
    frame_check(8'h0D, 0);
    frame_check(8'h0A, 0);
    @(negedge clk);
    idle_check("after_3");

    // Fill to full, drop the 18th, then push+pop while full at a stop-bit end
    for (int i = 0; i < 17; i++) exp_q[i] = 8'(i * 37 + 5);
    late_b    = 8'hE7;
    exp_q[17] = late_b;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          push      = 1'b1;
          push_data = 8'(i * 37 + 5);
          if (i == 16) chk("full_after_16", 32'(full), 32'd0);
          if (i == 17) chk("full_after_17", 32'(full), 32'd1);
          @(negedge clk);
        end
        push = 1'b0;
        chk("full_after_drop", 32'(full), 32'd1);
        repeat (int'(FRAME_CLK) + 1 - 18) @(negedge clk);
        push      = 1'b1;
        push_data = late_b;
        @(negedge clk);
        push = 1'b0;
        chk("full_after_pushpop", 32'(full), 32'd1);
      end
      begin
        repeat (2) @(negedge clk);
        for (int j = 0; j < 18; j++) frame_check(exp_q[j], 0);
      end
    join
    @(negedge clk);
    idle_check("after_fill");

    // Reset during data bit 3 with a second byte queued
    push      = 1'b1;
    push_data = 8'h35;
    @(negedge clk);
    push_data = 8'hC3;
    @(negedge clk);
    push = 1'b0;
    chk("start_lat_35", 32'(tx), 32'd0);
    repeat (340) @(negedge clk);
    chk("pre_rst_bit3", 32'(tx), 32'd0);
    #2 rst = 1'b1;
    #1 idle_check("mid_rst");
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    bad_tx   = 0;
    bad_done = 0;
    bad_busy = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (tx !== 1'b1)      bad_tx++;
      if (tx_done !== 1'b0) bad_done++;
      if (tx_busy !== 1'b0) bad_busy++;
    end
    chk("post_rst_tx_high", 32'(bad_tx), 32'd0);
    chk("post_rst_no_done", 32'(bad_done), 32'd0);
    chk("post_rst_not_busy", 32'(bad_busy), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    push      = 1'b1;
    push_data = 8'hA5;
    @(negedge clk);
    push = 1'b0;
    chk("lat_a5_tx_high", 32'(tx), 32'd1);
    @(negedge clk);
    frame_check(8'hA5, 0);
    @(negedge clk);
    idle_check("after_a5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
